// File: rtl/alu_batch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_batch_pkg
// Purpose  : Opcode/state types and combinational helpers for alu_batch_top.
// Revision : 1.0
// ============================================================================
package alu_batch_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_PASSA = 4'd8,
        OP_PASSB = 4'd9
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Widest operand alu_eval supports; callers zero-extend and truncate.
    localparam int ALU_MAX_W = 64;

    function automatic int cmd_w(input int data_w, input int ch_w);
        return ch_w + 4 + 2 * data_w;
    endfunction

    function automatic logic op_defined(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    function automatic logic [ALU_MAX_W-1:0] alu_eval(
        input logic [3:0]           op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input logic [ALU_MAX_W-1:0] width
    );
        logic [ALU_MAX_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOT:   r = ~a;
            OP_SHL:   r = (b >= width) ? '0 : (a << b);
            OP_SHR:   r = (b >= width) ? '0 : (a >> b);
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_batch_top_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram
// Purpose  : Simple dual-port RAM, synchronous write A, registered read B.
// Revision : 1.0
// ============================================================================
module dp_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wena_i,
    input  logic [AW-1:0] addra_i,
    input  logic [DW-1:0] dina_i,
    input  logic          renb_i,
    input  logic [AW-1:0] addrb_i,
    output logic [DW-1:0] doutb_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] doutb_q;

    always_ff @(posedge clk_i) begin
        if (wena_i) begin
            mem_q[addra_i] <= dina_i;
        end
    end

    // Read-first: a same-edge write is not visible until the next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            doutb_q <= '0;
        end else if (renb_i) begin
            doutb_q <= mem_q[addrb_i];
        end
    end

    assign doutb_o = doutb_q;

endmodule
`default_nettype wire

// File: rtl/alu_batch_top.sv
`default_nettype none
// ============================================================================
// Module   : alu_batch_top
// Purpose  : Runs a batch of ALU commands from a command RAM into NUM_CH
//            result RAMs, one command per three-cycle slot.
// Revision : 1.0
// ============================================================================
module alu_batch_top
    import alu_batch_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 4,
    parameter  int NUM_CH = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CMD_W  = cmd_w(DATA_W, CH_W)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       Cmd_WENA,
    input  logic [ADDR_W-1:0]          Cmd_ADDRA,
    input  logic [CMD_W-1:0]           Cmd_DINA,
    input  logic [ADDR_W:0]            Run_Len,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic [NUM_CH*ADDR_W-1:0]   Trans_Mem_ADDRB,
    input  logic [NUM_CH-1:0]          Trans_Mem_RENB,
    output logic [NUM_CH*DATA_W-1:0]   Trans_Mem_DOUTB
);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [CH_W-1:0]     dst_q, dst_d;
    logic                bad_q, bad_d;

    logic                busy_w;
    logic                cmd_we;
    logic                cmd_re;
    logic [CMD_W-1:0]    cmd_rd;
    logic [CH_W-1:0]     cmd_dst;
    logic [3:0]          cmd_op;
    logic [DATA_W-1:0]   cmd_opa;
    logic [DATA_W-1:0]   cmd_opb;
    logic                dst_in_range;
    logic [DATA_W-1:0]   alu_res;

    assign busy_w = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WRITE);
    assign busy   = busy_w;
    assign done   = (state_q == S_DONE);
    assign err    = err_q;

    assign cmd_we = Cmd_WENA && !busy_w;
    assign cmd_re = (state_q == S_FETCH);

    dp_ram #(
        .DW (CMD_W),
        .AW (ADDR_W)
    ) u_cmd_ram (
        .clk_i   (clock),
        .rst_i   (reset),
        .wena_i  (cmd_we),
        .addra_i (Cmd_ADDRA),
        .dina_i  (Cmd_DINA),
        .renb_i  (cmd_re),
        .addrb_i (idx_q[ADDR_W-1:0]),
        .doutb_o (cmd_rd)
    );

    // Command word layout: {dst, op, opa, opb}
    assign cmd_dst = cmd_rd[CMD_W-1 -: CH_W];
    assign cmd_op  = cmd_rd[2*DATA_W +: 4];
    assign cmd_opa = cmd_rd[DATA_W +: DATA_W];
    assign cmd_opb = cmd_rd[0 +: DATA_W];

    assign dst_in_range = (32'(cmd_dst) < 32'(NUM_CH));
    assign alu_res = DATA_W'(alu_eval(cmd_op, ALU_MAX_W'(cmd_opa), ALU_MAX_W'(cmd_opb),
                                      ALU_MAX_W'(DATA_W)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
        res_d   = res_q;
        dst_d   = dst_q;
        bad_d   = bad_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (Run_Len != '0) begin
                        idx_d   = '0;
                        len_d   = Run_Len;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                res_d   = alu_res;
                dst_d   = cmd_dst;
                bad_d   = !op_defined(cmd_op) || !dst_in_range;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bad_q) begin
                    err_d = 1'b1;
                end
                if (idx_q == len_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            dst_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
            res_q   <= res_d;
            dst_q   <= dst_d;
            bad_q   <= bad_d;
        end
    end

    // An out-of-range dst matches no channel, so nothing is written.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_res_mem
            logic res_we;
            assign res_we = (state_q == S_WRITE) && (dst_q == CH_W'(c));

            dp_ram #(
                .DW (DATA_W),
                .AW (ADDR_W)
            ) u_res_ram (
                .clk_i   (clock),
                .rst_i   (reset),
                .wena_i  (res_we),
                .addra_i (idx_q[ADDR_W-1:0]),
                .dina_i  (res_q),
                .renb_i  (Trans_Mem_RENB[c]),
                .addrb_i (Trans_Mem_ADDRB[c*ADDR_W +: ADDR_W]),
                .doutb_o (Trans_Mem_DOUTB[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_batch_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_batch_top
// Purpose  : Self-checking bench for alu_batch_top (three parameterisations).
// Revision : 1.0
// ============================================================================
module tb_alu_batch_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;

    // instance 0: defaults (8/4/2)
    logic a_we, a_start, a_busy, a_done, a_err;
    logic [3:0]  a_addra;
    logic [20:0] a_din;
    logic [4:0]  a_len;
    logic [7:0]  a_addrb;
    logic [1:0]  a_renb;
    logic [15:0] a_dout;
    // instance 1: 16/5/4
    logic b_we, b_start, b_busy, b_done, b_err;
    logic [4:0]  b_addra;
    logic [37:0] b_din;
    logic [5:0]  b_len;
    logic [19:0] b_addrb;
    logic [3:0]  b_renb;
    logic [63:0] b_dout;
    // instance 2: 8/4/3 (dst field can express an out-of-range channel)
    logic c_we, c_start, c_busy, c_done, c_err;
    logic [3:0]  c_addra;
    logic [21:0] c_din;
    logic [4:0]  c_len;
    logic [11:0] c_addrb;
    logic [2:0]  c_renb;
    logic [23:0] c_dout;

    alu_batch_top #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2)) u_a (
        .clock(clk), .reset(rst), .Cmd_WENA(a_we), .Cmd_ADDRA(a_addra), .Cmd_DINA(a_din),
        .Run_Len(a_len), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
        .Trans_Mem_ADDRB(a_addrb), .Trans_Mem_RENB(a_renb), .Trans_Mem_DOUTB(a_dout));

    alu_batch_top #(.DATA_W(16), .ADDR_W(5), .NUM_CH(4)) u_b (
        .clock(clk), .reset(rst), .Cmd_WENA(b_we), .Cmd_ADDRA(b_addra), .Cmd_DINA(b_din),
        .Run_Len(b_len), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
        .Trans_Mem_ADDRB(b_addrb), .Trans_Mem_RENB(b_renb), .Trans_Mem_DOUTB(b_dout));

    alu_batch_top #(.DATA_W(8), .ADDR_W(4), .NUM_CH(3)) u_c (
        .clock(clk), .reset(rst), .Cmd_WENA(c_we), .Cmd_ADDRA(c_addra), .Cmd_DINA(c_din),
        .Run_Len(c_len), .start(c_start), .busy(c_busy), .done(c_done), .err(c_err),
        .Trans_Mem_ADDRB(c_addrb), .Trans_Mem_RENB(c_renb), .Trans_Mem_DOUTB(c_dout));

    typedef struct {
        int         op;
        int         a;
        int         b;
        int         dst;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [14];

    logic [15:0] model [4][32];
    bit          known [4][32];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] enc(input int inst, input int dst, input int op,
                                        input int a, input int b);
        int dw;
        dw = (inst == 1) ? 16 : 8;
        return (64'(dst) << (4 + 2*dw)) | (64'(op) << (2*dw)) | (64'(a) << dw) | 64'(b);
    endfunction

    // Reference ALU written with plain integer arithmetic on 16-bit data.
    function automatic int ref_alu16(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 65536;
            1: return (a - b + 65536) % 65536;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 65535 - a;
            6: return (b >= 16) ? 0 : (a * (2**b)) % 65536;
            7: return (b >= 16) ? 0 : a / (2**b);
            8: return a;
            9: return b;
            default: return 0;
        endcase
    endfunction

    task automatic set_cmd(input int inst, input logic we, input int addr, input logic [63:0] w);
        case (inst)
            0: begin a_we = we; a_addra = 4'(addr); a_din = 21'(w); end
            1: begin b_we = we; b_addra = 5'(addr); b_din = 38'(w); end
            default: begin c_we = we; c_addra = 4'(addr); c_din = 22'(w); end
        endcase
    endtask

    task automatic wr_cmd(input int inst, input int addr, input logic [63:0] w);
        set_cmd(inst, 1'b1, addr, w);
        @(negedge clk);
        set_cmd(inst, 1'b0, 0, 64'd0);
    endtask

    task automatic set_start(input int inst, input logic s, input int n);
        case (inst)
            0: begin a_start = s; a_len = 5'(n); end
            1: begin b_start = s; b_len = 6'(n); end
            default: begin c_start = s; c_len = 5'(n); end
        endcase
    endtask

    function automatic logic get_busy(input int inst);
        case (inst)
            0: return a_busy;
            1: return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic get_done(input int inst);
        case (inst)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic get_err(input int inst);
        case (inst)
            0: return a_err;
            1: return b_err;
            default: return c_err;
        endcase
    endfunction

    task automatic rd(input int inst, input int ch, input int addr, output logic [15:0] d);
        case (inst)
            0: begin a_renb = '0; a_renb[ch] = 1'b1; a_addrb[ch*4 +: 4] = 4'(addr); end
            1: begin b_renb = '0; b_renb[ch] = 1'b1; b_addrb[ch*5 +: 5] = 5'(addr); end
            default: begin c_renb = '0; c_renb[ch] = 1'b1; c_addrb[ch*4 +: 4] = 4'(addr); end
        endcase
        @(negedge clk);
        case (inst)
            0: d = {8'h00, a_dout[ch*8 +: 8]};
            1: d = b_dout[ch*16 +: 16];
            default: d = {8'h00, c_dout[ch*8 +: 8]};
        endcase
        a_renb = '0; b_renb = '0; c_renb = '0;
    endtask

    // Starts a batch, watches busy/done for a bounded window; optionally
    // drives start + a command write (junk to addr 13) mid-run.
    task automatic run_check(input string nm, input int inst, input int n, input int inject_at);
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        set_start(inst, 1'b1, n);
        @(negedge clk);
        set_start(inst, 1'b0, n);
        for (int i = 1; i <= 3*n + 4; i++) begin
            if (i == inject_at) begin
                set_start(inst, 1'b1, n);
                set_cmd(inst, 1'b1, 13, enc(inst, 0, 9, 8'hEE, 8'hEE));
            end
            if (get_busy(inst)) busy_cnt++;
            if (get_done(inst)) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            @(negedge clk);
            if (i == inject_at) begin
                set_start(inst, 1'b0, n);
                set_cmd(inst, 1'b0, 0, 64'd0);
            end
        end
        check({nm, " busy_cycles"}, 64'(busy_cnt), 64'(3*n));
        check({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({nm, " done_cycle"},  64'(done_at),  64'(3*n + 1));
    endtask

    task automatic readback_tbl(input string nm, input int count);
        logic [15:0] d;
        for (int i = 0; i < count; i++) begin
            rd(0, tbl[i].dst, i, d);
            check($sformatf("%s ch%0d[%0d]", nm, tbl[i].dst, i), 64'(d), 64'(tbl[i].exp));
        end
    endtask

    initial begin
        logic [15:0] d;
        int          dcnt;
        bit          exp_err;
        int          ad [4];

        tbl[0]  = '{0,  'h0F, 'h01, 0, 8'h10};
        tbl[1]  = '{1,  'h00, 'h01, 1, 8'hFF};
        tbl[2]  = '{4,  'hA5, 'hFF, 0, 8'h5A};
        tbl[3]  = '{6,  'h01, 'h03, 1, 8'h08};
        tbl[4]  = '{2,  'hF0, 'h3C, 0, 8'h30};
        tbl[5]  = '{3,  'hF0, 'h0F, 1, 8'hFF};
        tbl[6]  = '{5,  'h5A, 'h00, 0, 8'hA5};
        tbl[7]  = '{7,  'h80, 'h07, 1, 8'h01};
        tbl[8]  = '{6,  'hFF, 'h08, 0, 8'h00};
        tbl[9]  = '{7,  'hFF, 'h09, 1, 8'h00};
        tbl[10] = '{8,  'h12, 'h34, 0, 8'h12};
        tbl[11] = '{9,  'h12, 'h34, 1, 8'h34};
        tbl[12] = '{0,  'hFF, 'h02, 0, 8'h01};
        tbl[13] = '{6,  'h81, 'h01, 1, 8'h02};

        set_cmd(0, 1'b0, 0, 64'd0); set_cmd(1, 1'b0, 0, 64'd0); set_cmd(2, 1'b0, 0, 64'd0);
        set_start(0, 1'b0, 0); set_start(1, 1'b0, 0); set_start(2, 1'b0, 0);
        a_addrb = '0; b_addrb = '0; c_addrb = '0;
        a_renb = '1; b_renb = '1; c_renb = '1;
        for (int c = 0; c < 4; c++) for (int j = 0; j < 32; j++) known[c][j] = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("reset a_dout", 64'(a_dout), 64'd0);
        check("reset b_dout", b_dout, 64'd0);
        check("reset c_dout", 64'(c_dout), 64'd0);
        check("reset busy/done/err", {61'd0, a_busy | b_busy | c_busy,
              a_done | b_done | c_done, a_err | b_err | c_err}, 64'd0);
        rst = 1'b0;
        a_renb = '0; b_renb = '0; c_renb = '0;
        @(negedge clk);

        // Four-command batch, then the full table with a mid-run start/write
        for (int i = 0; i < 14; i++)
            wr_cmd(0, i, enc(0, tbl[i].dst, tbl[i].op, tbl[i].a, tbl[i].b));
        run_check("run4", 0, 4, 0);
        check("run4 err", 64'(a_err), 64'd0);
        readback_tbl("run4", 4);

        run_check("run14_inject", 0, 14, 4);
        check("run14 err", 64'(a_err), 64'd0);
        readback_tbl("run14", 14);

        // Zero-length batch
        run_check("run0", 0, 0, 0);
        rd(0, 0, 0, d);
        check("run0 ch0[0] unchanged", 64'(d), 64'h10);

        // Undefined opcode
        wr_cmd(0, 0, enc(0, 0, 12, 'h11, 'h22));
        run_check("badop", 0, 1, 0);
        check("badop err", 64'(a_err), 64'd1);
        rd(0, 0, 0, d);
        check("badop ch0[0]", 64'(d), 64'h00);
        rd(0, 1, 1, d);
        check("badop ch1[1] kept", 64'(d), 64'hFF);

        // Reset in the middle of a batch
        set_start(0, 1'b1, 14);
        @(negedge clk);
        set_start(0, 1'b0, 14);
        repeat (4) @(negedge clk);
        check("midrun err before reset", 64'(a_err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun reset busy/done/err", {61'd0, a_busy, a_done, a_err}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 45; i++) begin
            if (a_done || a_busy) dcnt++;
            @(negedge clk);
        end
        check("midrun no activity after reset", 64'(dcnt), 64'd0);
        wr_cmd(0, 0, enc(0, tbl[0].dst, tbl[0].op, tbl[0].a, tbl[0].b));
        run_check("after_reset", 0, 14, 0);
        check("after_reset err", 64'(a_err), 64'd0);
        readback_tbl("after_reset", 14);

        // Out-of-range destination channel (NUM_CH=3, dst=3)
        wr_cmd(2, 0, enc(2, 0, 8, 'h11, 0));
        wr_cmd(2, 1, enc(2, 1, 8, 'h22, 0));
        wr_cmd(2, 2, enc(2, 2, 8, 'h33, 0));
        run_check("c_prep", 2, 3, 0);
        check("c_prep err", 64'(get_err(2)), 64'd0);
        for (int i = 0; i < 3; i++) wr_cmd(2, i, enc(2, 3, 0, 'h55, 'h01));
        run_check("c_baddst", 2, 3, 0);
        check("c_baddst err", 64'(get_err(2)), 64'd1);
        rd(2, 0, 0, d); check("c_baddst ch0[0]", 64'(d), 64'h11);
        rd(2, 1, 1, d); check("c_baddst ch1[1]", 64'(d), 64'h22);
        rd(2, 2, 2, d); check("c_baddst ch2[2]", 64'(d), 64'h33);

        // Random batches on the 16-bit, 4-channel instance
        for (int batch = 0; batch < 2; batch++) begin
            exp_err = 1'b0;
            for (int i = 0; i < 32; i++) begin
                int op, dst, a, b;
                op  = int'($urandom_range(0, 15));
                dst = int'($urandom_range(0, 3));
                a   = int'($urandom_range(0, 65535));
                b   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20))
                                                 : int'($urandom_range(0, 65535));
                wr_cmd(1, i, enc(1, dst, op, a, b));
                model[dst][i] = 16'(ref_alu16(op, a, b));
                known[dst][i] = 1'b1;
                if (op >= 10) exp_err = 1'b1;
            end
            run_check($sformatf("b_rand%0d", batch), 1, 32, 0);
            check($sformatf("b_rand%0d err", batch), 64'(b_err), 64'(exp_err));
        end
        for (int i = 0; i < 32; i++) begin
            b_renb = 4'hF;
            for (int c = 0; c < 4; c++) begin
                ad[c] = (i + 7*c) % 32;
                b_addrb[c*5 +: 5] = 5'(ad[c]);
            end
            @(negedge clk);
            for (int c = 0; c < 4; c++)
                if (known[c][ad[c]])
                    check($sformatf("b ch%0d[%0d]", c, ad[c]), 64'(b_dout[c*16 +: 16]),
                          64'(model[c][ad[c]]));
        end
        // With RENB low the outputs hold the last read data
        b_renb = 4'h0;
        for (int c = 0; c < 4; c++) b_addrb[c*5 +: 5] = 5'((ad[c] + 1) % 32);
        @(negedge clk);
        for (int c = 0; c < 4; c++)
            if (known[c][ad[c]])
                check($sformatf("b hold ch%0d", c), 64'(b_dout[c*16 +: 16]),
                      64'(model[c][ad[c]]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
